// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: FSM state type, S-box tables and the fixed bit permutations.
// Bit 1 of every S-DES vector is the MSB, so standard position k maps to index [WIDTH-k].
`default_nettype none

package sdes_pkg;

    localparam int BLK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R1   = 2'd1,
        R2   = 2'd2,
        OUT  = 2'd3
    } sdes_state_t;

    localparam logic [1:0] S0 [4][4] = '{
        '{2'd1, 2'd0, 2'd3, 2'd2},
        '{2'd3, 2'd2, 2'd1, 2'd0},
        '{2'd0, 2'd2, 2'd1, 2'd3},
        '{2'd3, 2'd1, 2'd3, 2'd2}
    };

    localparam logic [1:0] S1 [4][4] = '{
        '{2'd0, 2'd1, 2'd2, 2'd3},
        '{2'd2, 2'd0, 2'd1, 2'd3},
        '{2'd3, 2'd0, 2'd1, 2'd0},
        '{2'd2, 2'd1, 2'd0, 2'd3}
    };

    // IP = 2 6 3 1 4 8 5 7
    function automatic logic [7:0] ip8(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    // IP^-1 = 4 1 3 5 7 2 8 6
    function automatic logic [7:0] ip8_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    // EP = 4 1 2 3 2 3 4 1
    function automatic logic [7:0] ep4to8(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    // P4 = 2 4 3 1
    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdes_cipher_seq_if.sv
// Request/response handshake bundle between the controlling FSM and the S-DES engine.
`default_nettype none

interface sdes_cipher_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] key1;
    logic [7:0] key2;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, key1, key2, mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, key1, key2, mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/sdes_fk.sv
// Combinational S-DES round function F(R,k): expand, key-mix, S-box substitute, P4.
`default_nettype none

module sdes_fk
    import sdes_pkg::*;
(
    input  logic [3:0] half,
    input  logic [7:0] subkey,
    output logic [3:0] f
);

    logic [7:0] mixed;
    logic [1:0] s0_out;
    logic [1:0] s1_out;

    // Row comes from the outer bits {1,4}, column from the inner bits {2,3}.
    always_comb begin
        mixed  = ep4to8(half) ^ subkey;
        s0_out = S0[{mixed[7], mixed[4]}][{mixed[6], mixed[5]}];
        s1_out = S1[{mixed[3], mixed[0]}][{mixed[2], mixed[1]}];
        f      = p4({s0_out, s1_out});
    end

endmodule

`default_nettype wire

// File: rtl/sdes_cipher_seq.sv
// Multi-cycle S-DES encrypt/decrypt engine: one Feistel round per clock behind a valid/ready handshake.
`default_nettype none

module sdes_cipher_seq
    import sdes_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    sdes_cipher_seq_if.slave   bus
);

    generate
        if (DATA_W != BLK_W || KEY_W != BLK_W) begin : g_bad_width
            $error("sdes_cipher_seq: DATA_W and KEY_W are fixed at 8 by S-DES");
        end
    endgenerate

    sdes_state_t state;
    logic [3:0]  half_l;
    logic [3:0]  half_r;
    logic [7:0]  ka;
    logic [7:0]  kb;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ready_q;
    logic        busy_q;

    logic [7:0]  round_key;
    logic [3:0]  f_out;

    // A single F instance serves both rounds; only R2 uses the second subkey.
    assign round_key = (state == R2) ? kb : ka;

    sdes_fk u_fk (
        .half   (half_r),
        .subkey (round_key),
        .f      (f_out)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            half_l  <= 4'h0;
            half_r  <= 4'h0;
            ka      <= 8'h00;
            kb      <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && ready_q) begin
                        {half_l, half_r} <= ip8(bus.in_data);
                        // Decryption is the same network with the subkey order reversed.
                        ka      <= bus.mode ? bus.key2 : bus.key1;
                        kb      <= bus.mode ? bus.key1 : bus.key2;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= R1;
                    end
                end
                R1: begin
                    half_l <= half_r;
                    half_r <= half_l ^ f_out;
                    state  <= R2;
                end
                R2: begin
                    data_q  <= ip8_inv({half_l ^ f_out, half_r});
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire
